// File: rtl/pattern_generator.sv
// pattern_generator: back-pressurable burst source (inc / dec / LFSR / constant words).
// Define PATGEN_LFSR_EN to build LFSR mode; otherwise mode 2'b10 acts as increment.
module pattern_generator #(
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [1:0]        i_mode,
   input  logic [DATA_W-1:0] i_seed,
   input  logic              i_seed_load,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last,
   output logic              o_busy,
   output logic              o_done,
   output logic [15:0]       o_burst_cnt
);
   localparam int CNT_W = $clog2(BURST_LEN);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [DATA_W-1:0] data_q, data_d, next_data, load_data, start_data;
   logic [CNT_W-1:0]  beat_q, beat_d;
   logic              done_q, done_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              run, last, hs;
   assign run         = state_q == RUN;
   assign last        = run && beat_q == LAST_BEAT;
   assign hs          = run && i_ready;
   assign o_valid     = run;
   assign o_busy      = run;
   assign o_last      = last;
   assign o_data      = data_q;
   assign o_done      = done_q;
   assign o_burst_cnt = cnt_q;
`ifdef PATGEN_LFSR_EN
   localparam logic [DATA_W-1:0] MASK = DATA_W == 8  ? DATA_W'(32'hB8) :
                                        DATA_W == 16 ? DATA_W'(32'hB400) : DATA_W'(32'h8020_0003);
   always_comb begin
      next_data = mode_q == 2'b01 ? data_q - DATA_W'(1) :
                  mode_q == 2'b11 ? data_q :
                  mode_q == 2'b10 ? (data_q >> 1) ^ (data_q[0] ? MASK : '0) : data_q + DATA_W'(1);
      load_data  = i_seed_load ? i_seed : data_q;
      // all-zero is the LFSR lock-up state, so it is never allowed to start a run
      start_data = (i_mode == 2'b10 && load_data == '0) ? DATA_W'(1) : load_data;
   end
`else
   always_comb begin
      next_data  = mode_q == 2'b01 ? data_q - DATA_W'(1) :
                   mode_q == 2'b11 ? data_q : data_q + DATA_W'(1);
      load_data  = i_seed_load ? i_seed : data_q;
      start_data = load_data;
   end
`endif
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      data_d  = data_q;
      beat_d  = beat_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      if (!run) begin
         data_d = i_start ? start_data : load_data;
         if (i_start) begin
            mode_d  = i_mode;
            beat_d  = '0;
            state_d = RUN;
         end
      end else if (hs) begin
         data_d = next_data;
         beat_d = beat_q + CNT_W'(1);
         if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 16'd1;
         end
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         mode_q  <= '0;
         data_q  <= '0;
         beat_q  <= '0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         data_q  <= data_d;
         beat_q  <= beat_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_pattern_generator.sv
// tb_pattern_generator: directed burst table plus hand sequences for pattern_generator.
module tb_pattern_generator;
   localparam int BL = 64;
   typedef struct packed {
      logic [1:0]  mode;
      logic        ld;
      logic [31:0] seed;
      logic        rnd;
      logic [31:0] first;
   } vec_t;
   logic        clk = 1'b0, rst = 1'b1;
   logic        start = 1'b0, seed_load = 1'b0, ready = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [31:0] seed = '0;
   logic        valid, last, busy, done;
   logic [31:0] data;
   logic [15:0] bcnt;
   logic        l_start = 1'b0, l_seed_load = 1'b0;
   logic        l_valid, l_last, l_busy, l_done;
   logic [7:0]  l_data;
   logic [15:0] l_bcnt;
   int          n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   pattern_generator u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_seed(seed),
      .i_seed_load(seed_load), .i_ready(ready), .o_valid(valid), .o_data(data),
      .o_last(last), .o_busy(busy), .o_done(done), .o_burst_cnt(bcnt)
   );
   pattern_generator #(.DATA_W(8), .BURST_LEN(255)) u_lfsr (
      .i_clk(clk), .i_rst(rst), .i_start(l_start), .i_mode(2'b10), .i_seed(8'h00),
      .i_seed_load(l_seed_load), .i_ready(1'b1), .o_valid(l_valid), .o_data(l_data),
      .o_last(l_last), .o_busy(l_busy), .o_done(l_done), .o_burst_cnt(l_bcnt)
   );
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [31:0] nxt(input logic [1:0] m, input logic [31:0] d);
      case (m)
         2'b01:   return d - 32'd1;
         2'b11:   return d;
`ifdef PATGEN_LFSR_EN
         2'b10:   return (d >> 1) ^ (d[0] ? 32'h8020_0003 : 32'h0);
`endif
         default: return d + 32'd1;
      endcase
   endfunction
   // called at a negedge with the DUT idle; returns at the negedge after the final handshake
   task automatic run_burst(input logic [1:0] m, input logic ld, input logic [31:0] sd,
                            input logic rnd, input logic poke, input logic [31:0] first,
                            input logic [15:0] exp_cnt);
      logic [31:0] exp;
      int beats, budget;
      start = 1'b1; mode = m; seed_load = ld; seed = sd;
      @(negedge clk);
      start = 1'b0; seed_load = 1'b0;
      exp = first; beats = 0; budget = 0;
      while (beats < BL && budget < 2000) begin
         chk("valid", valid, 1'b1);
         chk("busy", busy, 1'b1);
         chk("data", data, exp);
         chk("last", last, beats == BL - 1);
         ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke && beats == 10) begin
            start = 1'b1; seed_load = 1'b1; seed = 32'hDEAD_BEEF; mode = ~m;
         end else if (poke && beats == BL - 1) start = 1'b1;
         else begin
            start = 1'b0; seed_load = 1'b0;
         end
         if (ready) begin
            exp = nxt(m, exp);
            beats++;
         end
         budget++;
         @(negedge clk);
      end
      chk("handshakes", beats, BL);
      start = 1'b0; ready = 1'b0;
      chk("done", done, 1'b1);
      chk("valid_after", valid, 1'b0);
      chk("busy_after", busy, 1'b0);
      chk("last_after", last, 1'b0);
      chk("burst_cnt", bcnt, exp_cnt);
      if (poke) begin
         @(negedge clk);
         chk("start_at_L_ignored", valid, 1'b0);
         chk("done_one_cycle", done, 1'b0);
      end
   endtask
   initial begin
      vec_t tbl[7];
      bit   seen[256];
      logic [7:0] lexp;
      int ndist;
      tbl[0] = '{2'b00, 1'b0, 32'h0,         1'b0, 32'h0000_0000};
      tbl[1] = '{2'b00, 1'b0, 32'h0,         1'b0, 32'h0000_0040};
      tbl[2] = '{2'b00, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE};
      tbl[3] = '{2'b01, 1'b0, 32'h0,         1'b0, 32'h0000_003E};
      tbl[4] = '{2'b01, 1'b1, 32'h5,         1'b1, 32'h0000_0005};
      tbl[5] = '{2'b11, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5};
`ifdef PATGEN_LFSR_EN
      tbl[6] = '{2'b10, 1'b1, 32'h0,         1'b0, 32'h0000_0001};
`else
      tbl[6] = '{2'b10, 1'b1, 32'h0,         1'b0, 32'h0000_0000};
`endif
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_valid", valid, 1'b0);
      chk("rst_data", data, 32'h0);
      chk("rst_last", last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_cnt", bcnt, 16'h0);
      chk("rst_l_valid", l_valid, 1'b0);
      for (int i = 0; i < 7; i++)
         run_burst(tbl[i].mode, tbl[i].ld, tbl[i].seed, tbl[i].rnd, 1'b0, tbl[i].first, 16'(i + 1));
      // mid-burst start/seed_load/mode and a start at the final handshake are all ignored
      run_burst(2'b00, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 16'd8);
      run_burst(2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h140, 16'd9);
      // 8-bit LFSR from a zero seed over a 255-word burst
      l_start = 1'b1; l_seed_load = 1'b1;
      @(negedge clk);
      l_start = 1'b0; l_seed_load = 1'b0;
`ifdef PATGEN_LFSR_EN
      lexp = 8'h01;
`else
      lexp = 8'h00;
`endif
      ndist = 0;
      for (int k = 0; k < 255; k++) begin
         chk("l_valid", l_valid, 1'b1);
         chk("l_data", l_data, lexp);
         chk("l_last", l_last, k == 254);
         if (!seen[l_data] && l_data != 8'h0) ndist++;
         seen[l_data] = 1'b1;
`ifdef PATGEN_LFSR_EN
         lexp = (lexp >> 1) ^ (lexp[0] ? 8'hB8 : 8'h00);
`else
         lexp = lexp + 8'd1;
`endif
         @(negedge clk);
      end
      chk("l_done", l_done, 1'b1);
      chk("l_valid_after", l_valid, 1'b0);
      chk("l_cnt", l_bcnt, 16'd1);
`ifdef PATGEN_LFSR_EN
      chk("l_distinct_nonzero", ndist, 255);
`else
      chk("l_distinct_nonzero", ndist, 254);
`endif
      // reset while word 10 is on the bus
      start = 1'b1; seed_load = 1'b1; seed = 32'h500; mode = 2'b00; ready = 1'b1;
      @(negedge clk);
      start = 1'b0; seed_load = 1'b0;
      repeat (10) @(negedge clk);
      chk("pre_rst_data", data, 32'h50A);
      chk("pre_rst_busy", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; ready = 1'b0;
      chk("mid_rst_valid", valid, 1'b0);
      chk("mid_rst_data", data, 32'h0);
      chk("mid_rst_last", last, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_cnt", bcnt, 16'h0);
      run_burst(2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 16'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pattern_generator.md
# pattern_generator

Parametrised, back-pressurable burst source that replaces the fixed 32-bit/64-word incrementing generator in the RAM system test path. On a start pulse it emits one burst of BURST_LEN words over a valid/ready handshake. Words follow a run-time selected pattern: increment, decrement, LFSR or constant. Successive bursts continue the sequence seamlessly. It feeds the RAM write controller and reports burst completion to the system FSM.

## Interface
- DATA_W, 32, data word width; legal 8, 16, 32 (LFSR masks defined only for these)
- BURST_LEN, 64, words per burst; legal 2..65536
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  start-burst pulse, honoured only in IDLE
- i_mode  in  2  pattern select, latched at accepted start: 00 inc, 01 dec, 10 LFSR, 11 constant
- i_seed  in  DATA_W  seed value
- i_seed_load  in  1  loads i_seed into data register, honoured only in IDLE
- i_ready  in  1  downstream ready
- o_valid  out  1  o_data valid this cycle
- o_data  out  DATA_W  current word
- o_last  out  1  high with final word of burst (qualified by o_valid)
- o_busy  out  1  high while in RUN
- o_done  out  1  one-cycle pulse after final handshake
- o_burst_cnt  out  16  completed bursts, wraps 65535 -> 0

## Operation
- States: IDLE, RUN. Reset -> IDLE.
- IDLE:
  - i_seed_load=1: data_reg <= i_seed. i_seed_load has priority over i_start in the same cycle; both take effect, and the burst starts from i_seed.
  - i_start=1: latch mode, beat_cnt <= 0, go to RUN.
- RUN: o_valid=1, o_data=data_reg.
  - On handshake (o_valid & i_ready): data_reg <= next(data_reg) and beat_cnt++.
  - Without handshake: o_data and o_last held stable.
- next(): inc d+1 mod 2^DATA_W; dec d-1 mod 2^DATA_W; constant d; LFSR Galois right shift, d>>1 XOR (d[0] ? MASK : 0).
  - MASK: 8'hB8, 16'hB400, 32'h80200003.
  - When LFSR mode is latched and data_reg=0, data_reg is forced to 1 at the start transition, so the all-zero lock-up state is never emitted.
- o_last = RUN & (beat_cnt == BURST_LEN-1).
- Handshake with o_last: go to IDLE, pulse o_done, o_burst_cnt++.
- Continuity: the next burst's first word is next() of the previous burst's last word. Wrap-around at 2^DATA_W is silent.
- i_start, i_seed_load and i_mode changes during RUN are ignored.
- beat_cnt width = clog2(BURST_LEN), internal.

## Timing
- Reset values: o_valid 0, o_data 0, o_last 0, o_busy 0, o_done 0, o_burst_cnt 0, data_reg 0, state IDLE.
- All outputs are registered or decoded from registers only; there is no combinational path from any input to any output.
- Start latency: i_start sampled at edge T, so o_valid=o_busy=1 from cycle T+1, first word = data_reg.
- Throughput: 1 word/cycle with i_ready held high, so a burst occupies exactly BURST_LEN cycles.
- Final handshake at cycle L: o_valid=o_busy=0 and o_done=1 at L+1.
- i_start is sampled at L+1 earliest; a start asserted at L is ignored.
- Minimum gap between bursts: 1 idle cycle.
- Reset mid-burst: next cycle all outputs are at reset values and the partial burst is not counted.

## Configuration
- PATGEN_LFSR_EN defined: LFSR mode (10) and its zero-seed fix-up are built.
- PATGEN_LFSR_EN undefined: no LFSR logic is instantiated, and mode 10 behaves exactly as increment (00).

## Test plan
- Default params, reset, i_start, i_ready=1, mode 00 -> 64 words 0..63, o_last on word 63, o_done at next cycle, o_burst_cnt=1. Second start -> 64..127.
- i_seed_load with 32'hFFFF_FFFE, mode 00, BURST_LEN=4 -> FFFF_FFFE, FFFF_FFFF, 0, 1; then mode 01 burst -> 2, 1, 0, FFFF_FFFF.
- Random i_ready toggling -> o_data and o_last stable while stalled, no word skipped or duplicated, exactly 64 handshakes.
- LFSR, DATA_W=8, seed 0, BURST_LEN=255 -> first word 8'h01, all 255 words distinct and nonzero. With PATGEN_LFSR_EN undefined -> 0..254.
- i_start and i_seed_load asserted mid-burst -> ignored. i_start at cycle L -> ignored. i_start at L+1 -> new burst, o_valid at L+2.
- i_rst asserted at word 10 -> all outputs at reset values next cycle, o_burst_cnt=0. Next burst starts at 0.
